// File: rtl/bidir_pkg.sv
// Shared lane geometry and FSM state type for the BiDir receive unpacker.
package bidir_pkg;

  localparam int unsigned LANE_W     = 16;
  localparam int unsigned N_LANES    = 3;
  localparam int unsigned LANE_IDX_W = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/bidir_lane_sel.sv
// Picks the lowest pending lane, the mask left after it, and whether it is the final one.
module bidir_lane_sel #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  rest,
  output logic          last
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
  end

  assign rest = mask & (mask - N'(1));
  assign last = (|mask) & ~(|rest);

endmodule

// File: rtl/bidir_rx_unpack.sv
// Splits wide BiDir receive beats into per-lane samples, skipping lanes with no strobes.
module bidir_rx_unpack
  import bidir_pkg::*;
#(
  parameter int unsigned IN_DW  = LANE_W * N_LANES,
  parameter int unsigned OUT_DW = LANE_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [IN_DW-1:0]      s_axis_tdata,
  input  logic [IN_DW/8-1:0]    s_axis_tstrb,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [OUT_DW-1:0]     m_axis_tdata,
  output logic [OUT_DW/8-1:0]   m_axis_tstrb,
  output logic                  m_axis_tlast,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      sample_cnt,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  strb_err
);

  localparam int unsigned NL = IN_DW / OUT_DW;
  localparam int unsigned SW = OUT_DW / 8;
  localparam int unsigned IW = (NL > 1) ? $clog2(NL) : 1;

  rx_state_t state, state_nxt;

  logic [IN_DW-1:0]   buf_data;
  logic [IN_DW/8-1:0] buf_strb;
  logic               buf_last;
  logic [NL-1:0]      rem_mask;

  logic [OUT_DW-1:0]  in_lane   [NL];
  logic [SW-1:0]      in_lstrb  [NL];
  logic [OUT_DW-1:0]  buf_lane  [NL];
  logic [SW-1:0]      buf_lstrb [NL];
  logic [NL-1:0]      in_mask;
  logic [NL-1:0]      in_part;

  logic [NL-1:0]      sel_mask;
  logic [NL-1:0]      sel_rest;
  logic [IW-1:0]      sel_idx;
  logic               sel_last;

  logic s_hs, m_hs, load_new, advance;

  // Lane views of the incoming beat and the buffered beat.
  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign in_lane[k]   = s_axis_tdata[k*OUT_DW +: OUT_DW];
    assign in_lstrb[k]  = s_axis_tstrb[k*SW +: SW];
    assign buf_lane[k]  = buf_data[k*OUT_DW +: OUT_DW];
    assign buf_lstrb[k] = buf_strb[k*SW +: SW];
    assign in_mask[k]   = |in_lstrb[k];
    assign in_part[k]   = (|in_lstrb[k]) & ~(&in_lstrb[k]);
  end

  assign m_hs          = m_axis_tvalid & m_axis_tready;
  assign s_axis_tready = (state == ST_EMPTY) | (m_hs & ~(|rem_mask));
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign load_new      = s_hs & (|in_mask);
  assign advance       = m_hs & (|rem_mask);
  assign sel_mask      = load_new ? in_mask : rem_mask;

  bidir_lane_sel #(
    .N  (NL),
    .IW (IW)
  ) u_lane_sel (
    .mask (sel_mask),
    .idx  (sel_idx),
    .rest (sel_rest),
    .last (sel_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Next state: a fresh non-empty beat always lands in SEND; the final lane drains to EMPTY.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (load_new) state_nxt = ST_SEND;
      ST_SEND:  if (!load_new && m_hs && !(|rem_mask)) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Beat buffer, captured on every accepted non-empty beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data <= '0;
      buf_strb <= '0;
      buf_last <= 1'b0;
    end else if (load_new) begin
      buf_data <= s_axis_tdata;
      buf_strb <= s_axis_tstrb;
      buf_last <= s_axis_tlast;
    end
  end

  // Output sample register and pending-lane mask; held while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
      rem_mask      <= '0;
    end else if (load_new || advance) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_new ? in_lane[sel_idx]  : buf_lane[sel_idx];
      m_axis_tstrb  <= load_new ? in_lstrb[sel_idx] : buf_lstrb[sel_idx];
      m_axis_tlast  <= sel_last & (load_new ? s_axis_tlast : buf_last);
      rem_mask      <= sel_rest;
    end else if (m_hs) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Status counters and sticky partial-strobe flag; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      strb_err   <= 1'b0;
    end else if (clr_cnt) begin
      sample_cnt <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      strb_err   <= 1'b0;
    end else begin
      if (m_hs)                   sample_cnt <= sample_cnt + CNT_W'(1);
      if (m_hs && m_axis_tlast)   frame_cnt  <= frame_cnt + CNT_W'(1);
      if (s_hs && !(|in_mask))    drop_cnt   <= drop_cnt + CNT_W'(1);
      if (load_new && (|in_part)) strb_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bidir_rx_unpack.sv
// Randomised and directed checking of bidir_rx_unpack against a sample-queue model.
module tb_bidir_rx_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [47:0] s_axis_tdata;
  logic [5:0]  s_axis_tstrb;
  logic        s_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tstrb;
  logic        m_axis_tlast;
  logic        clr_cnt;
  logic [31:0] sample_cnt;
  logic [31:0] frame_cnt;
  logic [31:0] drop_cnt;
  logic        strb_err;

  int total = 0;
  int bad   = 0;

  bidir_rx_unpack #(.IN_DW(48), .OUT_DW(16), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .clr_cnt       (clr_cnt),
    .sample_cnt    (sample_cnt),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt),
    .strb_err      (strb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: every sample still owed to the sink, in emission order.
  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  s;
    logic        l;
  } smp_t;

  smp_t        q[$];
  logic [31:0] ms, mf, md;
  logic        me;

  always @(negedge clk) begin : cmp
    logic  exp_tv, exp_trdy;
    int    hi;
    smp_t  smp;
    logic [1:0] ls;
    if (rst) begin
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("rst_tdata",  64'(m_axis_tdata),  64'(0));
      chk("rst_cnts",   64'({sample_cnt, frame_cnt} | 64'(drop_cnt)), 64'(0));
      chk("rst_err",    64'(strb_err), 64'(0));
      q.delete();
      ms = '0; mf = '0; md = '0; me = 1'b0;
    end else begin
      exp_tv   = (q.size() != 0);
      exp_trdy = (q.size() == 0) || (m_axis_tready && q.size() == 1);
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_tv));
      if (exp_tv) begin
        chk("m_tdata", 64'(m_axis_tdata), 64'(q[0].d));
        chk("m_tstrb", 64'(m_axis_tstrb), 64'(q[0].s));
        chk("m_tlast", 64'(m_axis_tlast), 64'(q[0].l));
      end
      chk("s_tready",   64'(s_axis_tready), 64'(exp_trdy));
      chk("sample_cnt", 64'(sample_cnt), 64'(ms));
      chk("frame_cnt",  64'(frame_cnt),  64'(mf));
      chk("drop_cnt",   64'(drop_cnt),   64'(md));
      chk("strb_err",   64'(strb_err),   64'(me));
      if (exp_tv && m_axis_tready) begin
        smp = q.pop_front();
        ms  = ms + 32'd1;
        if (smp.l) mf = mf + 32'd1;
      end
      if (s_axis_tvalid && exp_trdy) begin
        hi = -1;
        for (int k = 0; k < 3; k++) if (s_axis_tstrb[2*k +: 2] != 2'b00) hi = k;
        if (hi < 0) md = md + 32'd1;
        else begin
          for (int k = 0; k < 3; k++) begin
            ls = s_axis_tstrb[2*k +: 2];
            if (ls != 2'b00) begin
              q.push_back({s_axis_tdata[16*k +: 16], ls, s_axis_tlast && (k == hi)});
              if (ls != 2'b11) me = 1'b1;
            end
          end
        end
      end
      if (clr_cnt) begin
        ms = '0; mf = '0; md = '0; me = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [47:0] d, input logic [5:0] s, input logic l);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tlast  = l;
  endtask

  initial begin : stim
    logic [5:0]  trv, tvv;
    logic [15:0] dat [6];
    logic        acc;
    int          beats, cyc;
    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tstrb = '0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_trdy", 64'(s_axis_tready), 64'(1));

    // Full beat with frame end.
    tick(); drive(48'h3333_2222_1111, 6'h3F, 1'b1);
    tick(); s_axis_tvalid = 1'b0;
    @(negedge clk); chk("full_s0", 64'(m_axis_tdata), 64'h1111); chk("full_l0", 64'(m_axis_tlast), 64'(0));
    tick(); @(negedge clk); chk("full_s1", 64'(m_axis_tdata), 64'h2222); chk("full_l1", 64'(m_axis_tlast), 64'(0));
    tick(); @(negedge clk); chk("full_s2", 64'(m_axis_tdata), 64'h3333); chk("full_l2", 64'(m_axis_tlast), 64'(1));
    tick(); @(negedge clk);
    chk("full_done", 64'(m_axis_tvalid), 64'(0));
    chk("full_samples", 64'(sample_cnt), 64'(3));
    chk("full_frames", 64'(frame_cnt), 64'(1));

    // Back-to-back full beats.
    tick(); drive(48'h0C0C_0B0B_0A0A, 6'h3F, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) drive(48'h0F0F_0E0E_0D0D, 6'h3F, 1'b0);
      if (i == 4) s_axis_tvalid = 1'b0;
      @(negedge clk);
      trv[i-1] = s_axis_tready; tvv[i-1] = m_axis_tvalid; dat[i-1] = m_axis_tdata;
    end
    chk("b2b_trdy", 64'(trv), 64'(6'b100100));
    chk("b2b_tvalid", 64'(tvv), 64'(6'b111111));
    chk("b2b_d0", 64'(dat[0]), 64'h0A0A);
    chk("b2b_d3", 64'(dat[3]), 64'h0D0D);
    chk("b2b_d5", 64'(dat[5]), 64'h0F0F);
    tick(); @(negedge clk);
    chk("b2b_done", 64'(m_axis_tvalid), 64'(0));
    chk("b2b_samples", 64'(sample_cnt), 64'(9));

    // Middle lane inactive.
    tick(); drive(48'hCCCC_BBBB_AAAA, 6'h33, 1'b1);
    tick(); s_axis_tvalid = 1'b0;
    @(negedge clk); chk("skip_s0", 64'(m_axis_tdata), 64'hAAAA); chk("skip_l0", 64'(m_axis_tlast), 64'(0));
    tick(); @(negedge clk); chk("skip_s1", 64'(m_axis_tdata), 64'hCCCC); chk("skip_l1", 64'(m_axis_tlast), 64'(1));
    tick(); @(negedge clk);
    chk("skip_done", 64'(m_axis_tvalid), 64'(0));
    chk("skip_frames", 64'(frame_cnt), 64'(2));

    // All-zero strobes: dropped, tlast lost.
    tick(); drive(48'hDEAD_BEEF_CAFE, 6'h00, 1'b1);
    tick(); s_axis_tvalid = 1'b0;
    @(negedge clk); chk("drop_tvalid", 64'(m_axis_tvalid), 64'(0)); chk("drop_cnt1", 64'(drop_cnt), 64'(1));
    tick(); @(negedge clk); chk("drop_frames", 64'(frame_cnt), 64'(2));
    chk("err_clean", 64'(strb_err), 64'(0));

    // Partial strobe, then reset while holding a beat.
    tick(); drive(48'h0000_0000_0055, 6'h01, 1'b0);
    tick(); s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("part_data", 64'(m_axis_tdata), 64'h0055);
    chk("part_strb", 64'(m_axis_tstrb), 64'(2'b01));
    chk("part_err", 64'(strb_err), 64'(1));
    tick(); m_axis_tready = 1'b0; drive(48'h7777_6666_5555, 6'h3F, 1'b1);
    tick(); s_axis_tvalid = 1'b0;
    @(negedge clk); chk("hold_data", 64'(m_axis_tdata), 64'h5555);
    tick(); rst = 1'b1;
    #1;
    chk("arst_out", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast}), 64'(0));
    chk("arst_cnt", 64'(sample_cnt | frame_cnt | drop_cnt), 64'(0));
    chk("arst_err", 64'(strb_err), 64'(0));
    tick(); rst = 1'b0; m_axis_tready = 1'b1;
    @(negedge clk);
    chk("rel_trdy", 64'(s_axis_tready), 64'(1));
    chk("rel_tvalid", 64'(m_axis_tvalid), 64'(0));
    tick(); drive(48'h0000_0000_9999, 6'h03, 1'b0);
    tick(); s_axis_tvalid = 1'b0;
    @(negedge clk); chk("rel_first", 64'(m_axis_tdata), 64'h9999);
    tick();

    // Random traffic with backpressure and occasional counter clears.
    beats = 0; cyc = 0; acc = 1'b0;
    while (beats < 1000 && cyc < 20000) begin
      tick(); cyc++;
      clr_cnt       = ($urandom_range(0, 199) == 0);
      m_axis_tready = 1'($urandom_range(0, 1));
      if (!s_axis_tvalid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = 48'({$urandom(), $urandom()});
          s_axis_tlast  = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 5))
            0:       s_axis_tstrb = 6'h00;
            1:       s_axis_tstrb = 6'($urandom());
            default: s_axis_tstrb = {{2{1'($urandom_range(0, 1))}}, {2{1'($urandom_range(0, 1))}},
                                     {2{1'($urandom_range(0, 1))}}};
          endcase
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      if (acc) beats++;
    end
    chk("rand_beats", 64'(beats), 64'(1000));

    tick(); s_axis_tvalid = 1'b0; clr_cnt = 1'b0; m_axis_tready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("drain_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("drain_model", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bidir_rx_unpack.md
BIDIR_RX_UNPACK -- requirements
Module: bidir_rx_unpack

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- IN_DW, 48, input stream data width.
- OUT_DW, 16, output sample width; IN_DW/OUT_DW = 3 lanes.
- CNT_W, 32, status counter width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- s_axis_tvalid, in, 1, beat valid from the BiDir channel receive stream.
- s_axis_tready, out, 1, beat accept.
- s_axis_tdata, in, IN_DW, beat data; lane k = bits [16k+15:16k].
- s_axis_tstrb, in, IN_DW/8, byte strobes.
- s_axis_tlast, in, 1, frame end.
- m_axis_tvalid, out, 1, sample valid toward the rx FIFO.
- m_axis_tready, in, 1, FIFO accept.
- m_axis_tdata, out, OUT_DW, sample.
- m_axis_tstrb, out, OUT_DW/8, lane strobes.
- m_axis_tlast, out, 1, last sample of frame.
- clr_cnt, in, 1, synchronous counter clear.
- sample_cnt, out, CNT_W, output samples handshaken.
- frame_cnt, out, CNT_W, output tlast handshakes.
- drop_cnt, out, CNT_W, beats dropped (all strobes zero).
- strb_err, out, 1, sticky partial-lane-strobe flag.

Function
REQ-004 Lane k SHALL be active when either of its strobe bits is 1; the active-lane mask SHALL be captured with the data on each accepted beat.
REQ-005 Active lanes SHALL be emitted in ascending order (lane 0 first), one per m_axis handshake; inactive lanes SHALL be skipped with no idle cycle.
REQ-006 The state machine SHALL have two states. EMPTY: buffer holds nothing. SEND: buffer holds a beat with at least one pending lane.
REQ-007 Transitions: EMPTY->SEND on accepting a beat with a non-zero mask. SEND->EMPTY when the final pending lane handshakes and no beat is accepted in the same cycle. SEND->SEND when a new beat is accepted in that same cycle.
REQ-008 s_axis_tready SHALL equal (state==EMPTY) OR (m_axis_tvalid AND m_axis_tready AND the current lane is the last pending lane), giving a sustained rate of one sample per clock.
REQ-009 Latency SHALL be one clock: a beat accepted at edge N presents its first sample with m_axis_tvalid=1 after edge N.
REQ-010 m_axis_tdata, m_axis_tstrb and m_axis_tlast SHALL be registered and SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-011 m_axis_tlast SHALL be 1 only on the last active lane of a beat that carried s_axis_tlast=1.
REQ-012 A beat with tstrb all zero SHALL be accepted and discarded: drop_cnt increments, the state stays unchanged, and any tlast on that beat is lost.
REQ-013 A lane with strobe 01 or 10 SHALL be emitted with its strobe unchanged and SHALL set strb_err, which is cleared only by clr_cnt or rst.
REQ-014 Counters SHALL wrap modulo 2^CNT_W; clr_cnt SHALL take priority over a same-cycle increment, giving 0.

Reset
REQ-015 On rst, all of the following SHALL be 0 asynchronously:
- state=EMPTY and the mask.
- m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast.
- all counters and strb_err.
REQ-016 Reset asserted mid-beat SHALL discard the buffered beat with no partial output after release; s_axis_tready SHALL be 1 in the first cycle after release.

Structure
REQ-017 Lane width, lane count and the state enum SHALL live in a shared package bidir_pkg.
REQ-018 Next-lane selection (lowest set bit of the pending mask and a last-pending indication) SHALL be a combinational sub-module bidir_lane_sel.

Verification
REQ-019 Full beat 0x333322221111, tstrb=0x3F, tlast=1, m_tready held at 1 -> outputs 0x1111, 0x2222, 0x3333 on three consecutive cycles, tlast only on 0x3333; frame_cnt=1, sample_cnt=3.
REQ-020 Back-to-back full beats with tvalid held at 1 -> 6 samples in 6 consecutive cycles with s_tready high on cycles 3 and 6 only.
REQ-021 tstrb=0x33 (lane 1 inactive), tlast=1 -> two samples (lane 0, then lane 2); tlast on lane 2.
REQ-022 tstrb=0x00, tlast=1 -> no output; drop_cnt=1; frame_cnt unchanged.
REQ-023 m_tready toggled randomly -> output data and tlast stable under backpressure; no loss or duplication over 1000 beats.
REQ-024 tstrb=0x01 -> sample emitted with m_tstrb=01 and strb_err=1; then rst asserted during a SEND state -> all outputs 0 and the next sample seen is from the first new beat.
